// File: rtl/elastic_pipe_pkg.sv
// Shared constants and width helper for the elastic pipeline.
// Build option: ELASTIC_PIPE_SKID_EN adds a 2-entry skid buffer ahead of stage 0.
package elastic_pipe_pkg;

    localparam int SKID_DEPTH = 2;

`ifdef ELASTIC_PIPE_SKID_EN
    localparam bit SKID_EN = 1'b1;
`else
    localparam bit SKID_EN = 1'b0;
`endif

    // Counter must represent every stage plus any skid entries, all full at once.
    function automatic int occ_width(input int depth, input bit skid_en);
        return $clog2(depth + 1 + (skid_en ? SKID_DEPTH : 0));
    endfunction

endpackage

// File: rtl/elastic_pipeline_if.sv
// Producer/consumer handshake bundle for the elastic pipeline.
// The master side drives input data and consumer ready; the slave side is the pipeline.
interface elastic_pipeline_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/elastic_pipe_stage.sv
// One elastic pipeline stage: a valid flag and a data register.
// Data is only written by a valid source so bubbles never toggle the data flops.
module elastic_pipe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    input  logic             flush,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    logic             r_v;
    logic [WIDTH-1:0] r_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= 1'b0;
            r_d <= '0;
        end else begin
            if (flush) begin
                r_v <= 1'b0;
            end else if (load) begin
                r_v <= src_valid;
            end
            if (load && src_valid && !flush) begin
                r_d <= src_data;
            end
        end
    end

    assign v = r_v;
    assign d = r_d;

endmodule

// File: rtl/elastic_pipeline.sv
// Valid/ready register pipeline of DEPTH stages with bubble collapse, flush and occupancy.
// Build option: ELASTIC_PIPE_SKID_EN inserts a 2-entry skid buffer and registers in_ready.
module elastic_pipeline
    import elastic_pipe_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CNT_W = occ_width(DEPTH, SKID_EN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    elastic_pipeline_if.slave    bus,
    output logic [CNT_W-1:0]     occupancy
);

    logic [DEPTH-1:0] w_v;
    logic [WIDTH-1:0] w_d     [DEPTH];
    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_src_v;
    logic [WIDTH-1:0] w_src_d [DEPTH];

    logic             w_src_valid0;
    logic [WIDTH-1:0] w_src_data0;
    logic             w_in_ready;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [CNT_W-1:0] r_occ;

`ifdef ELASTIC_PIPE_SKID_EN
    localparam logic [1:0] SKID_FULL = 2'(SKID_DEPTH);

    logic [WIDTH-1:0] r_skid_data [SKID_DEPTH];
    logic             r_skid_rd;
    logic             r_skid_wr;
    logic [1:0]       r_skid_cnt;
    logic             r_in_ready;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_skid_cnt_next;

    assign w_push          = bus.in_valid & w_in_ready;
    assign w_pop           = w_adv[0] & (r_skid_cnt != 2'd0);
    assign w_skid_cnt_next = r_skid_cnt + {1'b0, w_push} - {1'b0, w_pop};

    // Ready comes from a flop so out_ready never reaches in_ready combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_skid_data[i] <= '0;
            end
            r_skid_rd  <= 1'b0;
            r_skid_wr  <= 1'b0;
            r_skid_cnt <= 2'd0;
            r_in_ready <= 1'b1;
        end else if (flush) begin
            r_skid_rd  <= 1'b0;
            r_skid_wr  <= 1'b0;
            r_skid_cnt <= 2'd0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_skid_data[r_skid_wr] <= bus.in_data;
                r_skid_wr              <= ~r_skid_wr;
            end
            if (w_pop) begin
                r_skid_rd <= ~r_skid_rd;
            end
            r_skid_cnt <= w_skid_cnt_next;
            r_in_ready <= (w_skid_cnt_next != SKID_FULL);
        end
    end

    assign w_in_ready   = r_in_ready & ~flush;
    assign w_src_valid0 = (r_skid_cnt != 2'd0);
    assign w_src_data0  = r_skid_data[r_skid_rd];
    assign w_in_xfer    = w_push;
`else
    assign w_in_ready   = w_adv[0] & ~flush;
    assign w_src_valid0 = bus.in_valid;
    assign w_src_data0  = bus.in_data;
    assign w_in_xfer    = bus.in_valid & w_in_ready;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            // A stage advances unless it and every stage after it are full and the consumer stalls.
            assign w_adv[gi] = bus.out_ready | ~(&w_v[DEPTH-1:gi]);

            if (gi == 0) begin : g_first
                assign w_src_v[gi] = w_src_valid0;
                assign w_src_d[gi] = w_src_data0;
            end else begin : g_next
                assign w_src_v[gi] = w_v[gi-1];
                assign w_src_d[gi] = w_d[gi-1];
            end

            elastic_pipe_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .load      (w_adv[gi]),
                .src_valid (w_src_v[gi]),
                .src_data  (w_src_d[gi]),
                .flush     (flush),
                .v         (w_v[gi]),
                .d         (w_d[gi])
            );
        end
    endgenerate

    assign w_out_xfer = w_v[DEPTH-1] & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + CNT_W'(w_in_xfer) - CNT_W'(w_out_xfer);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_v[DEPTH-1];
    assign bus.out_data  = w_d[DEPTH-1];
    assign occupancy     = r_occ;

endmodule

// File: tb/tb_elastic_pipeline.sv
// Directed bench for elastic_pipeline (DEPTH=3) with a scoreboard of accepted words.
// Adapts latency/capacity expectations when ELASTIC_PIPE_SKID_EN is defined.
module tb_elastic_pipeline;
    import elastic_pipe_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 3;
    localparam int CNT_W = occ_width(DEPTH, SKID_EN);
    localparam int LAT   = DEPTH + (SKID_EN ? 1 : 0);
    localparam int CAP   = DEPTH + (SKID_EN ? SKID_DEPTH : 0);

    logic             clk;
    logic             rst;
    logic             flush;
    logic [CNT_W-1:0] occupancy;

    elastic_pipeline_if #(.WIDTH(WIDTH)) bus ();

    elastic_pipeline #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int        errors = 0;
    int        checks = 0;
    int        cycle  = 0;
    int        model_cnt = 0;
    logic [31:0] sb [$];
    bit        lat_arm = 0;
    int        lat_in_cycle = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-14s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // One clock cycle: sample at negedge, score transfers, then advance to posedge+1.
    task automatic step();
        bit          w_in;
        bit          w_out;
        logic [31:0] exp;
        @(negedge clk);
        w_in  = bus.in_valid && bus.in_ready;
        w_out = bus.out_valid && bus.out_ready;
        if (w_out) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", bus.out_data, 32'hFFFF_FFFF);
            end else begin
                exp = sb.pop_front();
                chk("out_data", bus.out_data, exp);
            end
            if (lat_arm) begin
                chk("latency", 32'(cycle - lat_in_cycle), 32'(LAT));
                lat_arm = 0;
            end
        end
        if (lat_arm && w_in && lat_in_cycle < 0) lat_in_cycle = cycle;
        chk("occupancy", 32'(occupancy), 32'(model_cnt));
        if (flush) begin
            sb.delete();
            model_cnt = 0;
        end else begin
            if (w_in) sb.push_back(bus.in_data);
            model_cnt = model_cnt + int'(w_in) - int'(w_out);
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < CAP + 4; i++) step();
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
        chk("drain_occ", 32'(occupancy), 32'd0);
    endtask

    initial begin
        // 1: reset held with a valid producer
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hDEAD;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
            chk("rst_occ", 32'(occupancy), 32'd0);
            chk("rst_out_data", bus.out_data, 32'd0);
        end
        @(posedge clk);
        #2 rst = 1'b0;

        // 2: streaming
        lat_arm = 1;
        lat_in_cycle = -1;
        for (int i = 1; i <= 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(i);
            step();
        end
        chk("stream_occ", 32'(occupancy), 32'(LAT));
        drain();

        // 3: backpressure to full, held attempts, then release
        bus.out_ready = 1'b0;
        for (int i = 0; i < CAP + 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hA + 32'(i);
            step();
        end
        chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_occ", 32'(occupancy), 32'(CAP));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < CAP; i++) begin
            chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            step();
        end
        drain();

        // 4: bubble collapse under stall
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h5;
        step();
        bus.in_valid  = 1'b0;
        step();
        step();
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h6;
        step();
        bus.in_valid  = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("bub_occ", 32'(occupancy), 32'd2);
        chk("bub_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("bub_out_data", bus.out_data, 32'h5);
        drain();

        // 5: flush while full with a pending input
        bus.out_ready = 1'b0;
        for (int i = 0; i < CAP + 1; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'h40 + 32'(i);
            step();
        end
        bus.in_data = 32'h77;
        flush       = 1'b1;
        #1;
        chk("fl_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("fl_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("fl_occ_pre", 32'(occupancy), 32'(CAP));
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_occ_post", 32'(occupancy), 32'd0);
        chk("fl_out_valid0", {31'd0, bus.out_valid}, 32'd0);
        drain();

        // 6: asynchronous reset mid-stream, then restart
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'h20 + 32'(i);
            step();
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst_occ", 32'(occupancy), 32'd0);
        chk("arst_out_data", bus.out_data, 32'd0);
        sb.delete();
        model_cnt = 0;
        bus.in_valid = 1'b0;
        step();
        #2 rst = 1'b0;
        lat_arm = 1;
        lat_in_cycle = -1;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'h100 + 32'(i);
            step();
        end
        drain();
        chk("lat_seen", {31'd0, lat_arm}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
